// File: rtl/eth_mode_seq.sv
// eth_mode_seq: bus-clock sequencer for the Ethernet core mode word.
// It runs the TX (txrdy/txdone) and RX (rxrdy/rxdone) four-phase handshakes.
// It synchronizes the core status vector and emits one-cycle completion
// events, each carrying the captured error flags.
// Host mode changes are held back until both handshakes are quiescent.
module eth_mode_seq #(
    parameter int              TMO_W   = 20,
    parameter logic [TMO_W-1:0] TMO_MAX = 20'd1000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_wr_i,
    input  logic [6:0]  cfg_i,
    input  logic        rx_on_i,
    input  logic        tx_req_i,
    input  logic [10:0] tx_len_i,
    input  logic        rx_ack_i,
    input  logic [7:0]  sts_i,
    output logic [9:0]  ethmode_o,
    output logic [10:0] txcntb_o,
    output logic        tx_busy_o,
    output logic        cfg_busy_o,
    output logic        tx_evt_o,
    output logic        rx_evt_o,
    output logic [4:0]  err_o
);

    typedef enum logic [1:0] {T_IDLE, T_SET, T_WAIT, T_REL} tx_st_t;
    typedef enum logic [1:0] {R_OFF, R_ARM, R_HOLD, R_DONE} rx_st_t;

    // Last count value inside a handshake phase; reaching it means timeout.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - 1'b1;

    // Status bit positions inside the synchronized vector.
    localparam int S_RXRDY  = 6;
    localparam int S_TXDONE = 5;
    localparam int S_CRSERR = 4;
    localparam int S_TXERR  = 2;
    localparam int S_RXERR  = 1;
    localparam int S_CRCERR = 0;

    logic [7:0]       sts_m_q, sts_s_q;
    tx_st_t           tx_st_q, tx_st_d;
    rx_st_t           rx_st_q, rx_st_d;
    logic [TMO_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [TMO_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [10:0]      txcntb_q, txcntb_d;
    logic             txrdy_q, txrdy_d;
    logic             rxdone_q, rxdone_d;
    logic             rx_ena_q, rx_ena_d;
    logic [6:0]       mode_q, mode_d;
    logic [6:0]       pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic [4:0]       tx_cap_q, tx_cap_d;
    logic             tx_evt_q, tx_evt_d;
    logic             rx_evt_q, rx_evt_d;
    logic [4:0]       err_q, err_d;

    logic [7:0]       s;
    logic             apply;
    logic [4:0]       tx_err_v, rx_err_v;
    logic             sts_unused;

    assign s          = sts_s_q;
    // crs and mdc_err are synchronized with the rest but drive no decision.
    assign sts_unused = &{1'b0, s[7], s[3]};

    // Two-flop synchronizer for the asynchronous core status vector.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sts_m_q <= '0;
            sts_s_q <= '0;
        end else begin
            sts_m_q <= sts_i;
            sts_s_q <= sts_m_q;
        end
    end

    // Next-state logic: mode apply, TX FSM, RX FSM, and event/error merge.
    always_comb begin
        tx_st_d    = tx_st_q;
        rx_st_d    = rx_st_q;
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        txcntb_d   = txcntb_q;
        txrdy_d    = txrdy_q;
        rxdone_d   = rxdone_q;
        mode_d     = mode_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        tx_cap_d   = tx_cap_q;
        tx_evt_d   = 1'b0;
        rx_evt_d   = 1'b0;
        tx_err_v   = '0;
        rx_err_v   = '0;

        // Apply only when neither handshake is in flight.
        apply = pend_q && (tx_st_q == T_IDLE) &&
                ((rx_st_q == R_OFF) || (rx_st_q == R_ARM));
        if (apply) begin
            mode_d = pend_val_q;
            pend_d = 1'b0;
        end
        // A write arriving with an apply keeps the newer value pending.
        if (cfg_wr_i) begin
            pend_d     = 1'b1;
            pend_val_d = cfg_i;
        end

        unique case (tx_st_q)
            T_IDLE: begin
                if (tx_req_i) begin
                    txcntb_d = tx_len_i;
                    tx_st_d  = T_SET;
                end
            end
            T_SET: begin
                txrdy_d  = 1'b1;
                tx_cnt_d = '0;
                tx_cap_d = '0;
                tx_st_d  = T_WAIT;
            end
            T_WAIT: begin
                if (s[S_TXDONE]) begin
                    tx_cap_d = {1'b0, s[S_CRSERR], s[S_TXERR], 2'b00};
                    txrdy_d  = 1'b0;
                    tx_cnt_d = '0;
                    tx_st_d  = T_REL;
                end else if (tx_cnt_q == TMO_LAST) begin
                    tx_cap_d = 5'b10000;
                    txrdy_d  = 1'b0;
                    tx_cnt_d = '0;
                    tx_st_d  = T_REL;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            T_REL: begin
                if (!s[S_TXDONE] || (tx_cnt_q == TMO_LAST)) begin
                    tx_evt_d = 1'b1;
                    tx_err_v = tx_cap_q | {s[S_TXDONE], 4'b0000};
                    tx_st_d  = T_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_st_d = T_IDLE;
        endcase

        unique case (rx_st_q)
            R_OFF: begin
                if (rx_on_i) rx_st_d = R_ARM;
            end
            R_ARM: begin
                if (!rx_on_i) begin
                    rx_st_d = R_OFF;
                end else if (s[S_RXRDY]) begin
                    rx_evt_d = 1'b1;
                    rx_err_v = {3'b000, s[S_RXERR], s[S_CRCERR]};
                    rx_st_d  = R_HOLD;
                end
            end
            R_HOLD: begin
                // rx_on_i is not looked at here; the frame must be acked first.
                if (rx_ack_i) begin
                    rxdone_d = 1'b1;
                    rx_cnt_d = '0;
                    rx_st_d  = R_DONE;
                end
            end
            R_DONE: begin
                if (!s[S_RXRDY]) begin
                    rxdone_d = 1'b0;
                    rx_st_d  = rx_on_i ? R_ARM : R_OFF;
                end else if (rx_cnt_q == TMO_LAST) begin
                    rxdone_d = 1'b0;
                    rx_evt_d = 1'b1;
                    rx_err_v = 5'b10000;
                    rx_st_d  = R_OFF;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_st_d = R_OFF;
        endcase

        rx_ena_d = (rx_st_d != R_OFF);
        err_d    = tx_err_v | rx_err_v;
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tx_st_q    <= T_IDLE;
            rx_st_q    <= R_OFF;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            txcntb_q   <= '0;
            txrdy_q    <= 1'b0;
            rxdone_q   <= 1'b0;
            rx_ena_q   <= 1'b0;
            mode_q     <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            tx_cap_q   <= '0;
            tx_evt_q   <= 1'b0;
            rx_evt_q   <= 1'b0;
            err_q      <= '0;
        end else begin
            tx_st_q    <= tx_st_d;
            rx_st_q    <= rx_st_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            txcntb_q   <= txcntb_d;
            txrdy_q    <= txrdy_d;
            rxdone_q   <= rxdone_d;
            rx_ena_q   <= rx_ena_d;
            mode_q     <= mode_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            tx_cap_q   <= tx_cap_d;
            tx_evt_q   <= tx_evt_d;
            rx_evt_q   <= rx_evt_d;
            err_q      <= err_d;
        end
    end

    // mode_q holds {promis, mcast, skipb, setup, eloop, ieloop, iloop}.
    assign ethmode_o  = {mode_q[6], mode_q[5], rxdone_q, txrdy_q,
                         mode_q[4], mode_q[3], mode_q[2], mode_q[1],
                         mode_q[0], rx_ena_q};
    assign txcntb_o   = txcntb_q;
    assign tx_busy_o  = (tx_st_q != T_IDLE);
    assign cfg_busy_o = pend_q;
    assign tx_evt_o   = tx_evt_q;
    assign rx_evt_o   = rx_evt_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_eth_mode_seq.sv
// Directed/randomized bench for eth_mode_seq, run with a short timeout limit.
module tb_eth_mode_seq;

    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_wr_i;
    logic [6:0]  cfg_i;
    logic        rx_on_i;
    logic        tx_req_i;
    logic [10:0] tx_len_i;
    logic        rx_ack_i;
    logic [7:0]  sts_i;
    logic [9:0]  ethmode_o;
    logic [10:0] txcntb_o;
    logic        tx_busy_o, cfg_busy_o, tx_evt_o, rx_evt_o;
    logic [4:0]  err_o;

    int ncmp  = 0;
    int nfail = 0;

    // Monotonic activity counters, sampled on the falling edge.
    int         tx_evt_n = 0, rx_evt_n = 0, b6_n = 0, b7_n = 0;
    logic [4:0] tx_err_last = '0, rx_err_last = '0;

    // Expected applied mode value {promis..iloop}.
    logic [6:0] m_cfg = '0;

    eth_mode_seq #(.TMO_W(20), .TMO_MAX(20'd16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_wr_i(cfg_wr_i), .cfg_i(cfg_i),
        .rx_on_i(rx_on_i), .tx_req_i(tx_req_i), .tx_len_i(tx_len_i),
        .rx_ack_i(rx_ack_i), .sts_i(sts_i), .ethmode_o(ethmode_o),
        .txcntb_o(txcntb_o), .tx_busy_o(tx_busy_o), .cfg_busy_o(cfg_busy_o),
        .tx_evt_o(tx_evt_o), .rx_evt_o(rx_evt_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Activity monitor.
    always @(negedge clk_i) begin
        if (tx_evt_o) begin tx_evt_n++; tx_err_last = err_o; end
        if (rx_evt_o) begin rx_evt_n++; rx_err_last = err_o; end
        if (ethmode_o[6]) b6_n++;
        if (ethmode_o[7]) b7_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    // Mode word from its fields: cfg bit i lands on word bit pos[i].
    function automatic logic [9:0] word(input logic rxe, input logic txr,
                                        input logic rxd, input logic [6:0] c);
        int pos [7] = '{1, 2, 3, 4, 5, 8, 9};
        logic [9:0] w;
        w    = '0;
        w[0] = rxe;
        w[6] = txr;
        w[7] = rxd;
        for (int i = 0; i < 7; i++) w[pos[i]] = c[i];
        return w;
    endfunction

    function automatic logic [6:0] mode_bits(input logic [9:0] w);
        return {w[9], w[8], w[5], w[4], w[3], w[2], w[1]};
    endfunction

    // One TX handshake: txdone rises j cycles after txrdy, held h cycles.
    // With cfgw set, two config writes (junk, then val) land during the wait.
    task automatic tx_run(input logic [10:0] len, input int j, input int h,
                          input logic ce, input logic te, input logic [2:0] noise,
                          input logic cfgw, input logic [6:0] val);
        int n0, b0, k;
        n0 = tx_evt_n; b0 = b6_n;
        tx_req_i = 1'b1; tx_len_i = len;
        tick();
        tx_req_i = 1'b0; tx_len_i = 11'($urandom);
        tick();
        chk("tx_rdy_up", ethmode_o[6], 1'b1);
        chk("tx_len", txcntb_o, len);
        chk("tx_busy", tx_busy_o, 1'b1);
        if (cfgw) begin
            cfg_wr_i = 1'b1; cfg_i = ~val;
            tick();
            cfg_i = val;
            tick();
            cfg_wr_i = 1'b0;
            chk("cfg_pend", cfg_busy_o, 1'b1);
            chk("cfg_held", mode_bits(ethmode_o), m_cfg);
            tick(j - 3);
        end else begin
            tick(j - 1);
        end
        sts_i = '0;
        sts_i[5] = 1'b1; sts_i[4] = ce; sts_i[2] = te;
        sts_i[3] = noise[2]; sts_i[1:0] = noise[1:0];
        tick(h);
        sts_i = '0;
        k = 0;
        while (tx_busy_o && k < 100) begin
            if (cfgw) chk("cfg_wait", {cfg_busy_o, mode_bits(ethmode_o)}, {1'b1, m_cfg});
            tick(); k++;
        end
        chk("tx_finish_bound", k < 100, 1'b1);
        if (cfgw) chk("cfg_last_busy", cfg_busy_o, 1'b1);
        tick();
        if (cfgw) m_cfg = val;
        chk("tx_evt_cnt", tx_evt_n - n0, 1);
        chk("tx_err", tx_err_last, {1'b0, ce, te, 2'b00});
        chk("tx_rdy_len", b6_n - b0, j + 2);
        chk("tx_len_hold", txcntb_o, len);
        chk("tx_word", {cfg_busy_o, ethmode_o}, {1'b0, word(1'b0, 1'b0, 1'b0, m_cfg)});
    endtask

    initial begin
        int n0, b0, k;
        logic [6:0] v;
        logic re, ce;

        rst_i = 1'b0; cfg_wr_i = 0; cfg_i = '0; rx_on_i = 0; tx_req_i = 0;
        tx_len_i = '0; rx_ack_i = 0; sts_i = '0;

        // Reset held while inputs toggle.
        for (int i = 0; i < 6; i++) begin
            cfg_wr_i = 1'($urandom); cfg_i = 7'($urandom); rx_on_i = 1'($urandom);
            tx_req_i = 1'($urandom); tx_len_i = 11'($urandom); rx_ack_i = 1'($urandom);
            sts_i = 8'($urandom);
            tick();
            chk("rst_hold", {ethmode_o, txcntb_o, tx_busy_o, cfg_busy_o, tx_evt_o, rx_evt_o, err_o}, 0);
        end
        cfg_wr_i = 0; rx_on_i = 0; tx_req_i = 0; rx_ack_i = 0; sts_i = '0;
        rst_i = 1'b1;
        tick(3);
        chk("rst_release", {ethmode_o, txcntb_o, tx_busy_o, cfg_busy_o, tx_evt_o, rx_evt_o, err_o}, 0);

        // Idle config apply.
        v = 7'($urandom);
        cfg_wr_i = 1'b1; cfg_i = v;
        tick();
        cfg_wr_i = 1'b0;
        chk("cfg_idle_pend", {cfg_busy_o, ethmode_o}, {1'b1, 10'h000});
        tick();
        m_cfg = v;
        chk("cfg_idle_apply", {cfg_busy_o, ethmode_o}, {1'b0, word(1'b0, 1'b0, 1'b0, m_cfg)});

        // TX handshakes, including zero length.
        tx_run(11'd64, 10, 5, 1'b0, 1'b0, 3'b000, 1'b0, 7'h00);
        tx_run(11'd0, $urandom_range(3, 12), $urandom_range(1, 8), 1'($urandom), 1'($urandom),
               3'($urandom), 1'b0, 7'h00);
        tx_run(11'($urandom), $urandom_range(3, 12), $urandom_range(1, 8), 1'($urandom),
               1'($urandom), 3'($urandom), 1'b0, 7'h00);

        // TX timeout: txdone never comes.
        n0 = tx_evt_n; b0 = b6_n;
        tx_req_i = 1'b1; tx_len_i = 11'd100;
        tick();
        tx_req_i = 1'b0;
        tick();
        chk("tmo_rdy_up", ethmode_o[6], 1'b1);
        k = 0;
        while (tx_busy_o && k < 100) begin tick(); k++; end
        chk("tmo_bound", k < 100, 1'b1);
        tick();
        chk("tmo_rdy_len", b6_n - b0, TMO);
        chk("tmo_evt", tx_evt_n - n0, 1);
        chk("tmo_err", tx_err_last, 5'b10000);
        chk("tmo_idle", tx_busy_o, 1'b0);

        // Deferred config during the TX wait (with an overwrite).
        tx_run(11'd33, 8, 3, 1'b0, 1'b1, 3'b000, 1'b1, 7'b0000001);
        tx_run(11'($urandom), $urandom_range(4, 12), $urandom_range(1, 8), 1'($urandom),
               1'($urandom), 3'($urandom), 1'b1, 7'($urandom));

        // RX frame with ack.
        rx_on_i = 1'b1;
        tick();
        chk("rx_ena", ethmode_o[0], 1'b1);
        n0 = rx_evt_n;
        re = 1'($urandom);
        sts_i = '0; sts_i[6] = 1'b1; sts_i[1] = re; sts_i[0] = 1'b1;
        sts_i[4] = 1'($urandom); sts_i[2] = 1'($urandom);
        k = 0;
        while (rx_evt_n == n0 && k < 20) begin tick(); k++; end
        chk("rx_evt_bound", k < 20, 1'b1);
        chk("rx_err", rx_err_last, {3'b000, re, 1'b1});
        tick($urandom_range(0, 5));
        chk("rx_hold_nodone", ethmode_o[7], 1'b0);
        rx_ack_i = 1'b1;
        tick();
        rx_ack_i = 1'b0;
        chk("rx_done_up", ethmode_o[7], 1'b1);
        sts_i = '0;
        k = 0;
        while (ethmode_o[7] && k < 20) begin tick(); k++; end
        chk("rx_done_bound", k < 20, 1'b1);
        tick();
        chk("rx_ena_keep", ethmode_o[0], 1'b1);
        chk("rx_evt_once", rx_evt_n - n0, 1);

        // RX: rx_on drop deferred in hold, then rxdone timeout.
        n0 = rx_evt_n;
        ce = 1'($urandom);
        sts_i = '0; sts_i[6] = 1'b1; sts_i[0] = ce;
        k = 0;
        while (rx_evt_n == n0 && k < 20) begin tick(); k++; end
        chk("rx2_err", rx_err_last, {4'b0000, ce});
        rx_on_i = 1'b0;
        tick(2);
        chk("rx_off_deferred", ethmode_o[0], 1'b1);
        b0 = b7_n;
        rx_ack_i = 1'b1;
        tick();
        rx_ack_i = 1'b0;
        k = 0;
        while (rx_evt_n - n0 < 2 && k < 40) begin tick(); k++; end
        chk("rx_tmo_bound", k < 40, 1'b1);
        chk("rx_tmo_err", rx_err_last, 5'b10000);
        chk("rx_tmo_len", b7_n - b0, TMO);
        chk("rx_tmo_off", ethmode_o[1:0] & 2'b01, 2'b00);
        sts_i = '0;
        tick(3);

        // Reset in the middle of a TX wait.
        tx_req_i = 1'b1; tx_len_i = 11'd77;
        tick();
        tx_req_i = 1'b0;
        tick(4);
        chk("mid_rdy", ethmode_o[6], 1'b1);
        rst_i = 1'b0;
        #2;
        chk("mid_rst_async", {ethmode_o, txcntb_o, tx_busy_o, cfg_busy_o}, 0);
        m_cfg = '0;
        tick(2);
        rst_i = 1'b1;
        tick(2);
        tx_run(11'($urandom), $urandom_range(3, 12), $urandom_range(1, 8), 1'($urandom),
               1'($urandom), 3'($urandom), 1'b0, 7'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/eth_mode_seq.md
Name: eth_mode_seq

Overview:
- Bus-clock sequencer that drives the Ethernet core's 10-bit mode word and its TX length count.
- Runs the txrdy/txdone and rxrdy/rxdone four-phase handshakes with the core.
- Synchronizes the core's 8-bit status/error vector and raises one-cycle TX/RX completion events with captured error flags toward the host register file.
- Defers mode changes (loop, setup, mcast, promiscuous, skip-byte) until the handshakes are quiescent.

Parameters:
- TMO_W, 20, width of the handshake timeout counter.
- TMO_MAX, 20'd1000000, timeout limit in clk_i cycles per handshake phase.

Ports:
- clk_i  in  1  bus clock; sole clock.
- rst_i  in  1  asynchronous, active-low reset.
- cfg_wr_i  in  1  one-cycle strobe; latch cfg_i as the pending mode.
- cfg_i  in  7  {promis, mcast, skipb, setup, eloop, ieloop, iloop} = mode bits {9,8,5,4,3,2,1}.
- rx_on_i  in  1  host receive enable (level).
- tx_req_i  in  1  one-cycle transmit request.
- tx_len_i  in  11  frame length in bytes, sampled with tx_req_i.
- rx_ack_i  in  1  one-cycle strobe; host has consumed the received frame.
- sts_i  in  8  core status {crs, rxrdy, txdone, crs_err, mdc_err, tx_err, rx_err, rx_crc_err}; asynchronous to clk_i.
- ethmode_o  out  10  mode word to core: bit0 rx_ena, 1 iloop, 2 ieloop, 3 eloop, 4 setup, 5 skipb, 6 txrdy, 7 rxdone, 8 mcast, 9 promis.
- txcntb_o  out  11  TX byte count, stable while bit6 is high.
- tx_busy_o  out  1  TX FSM not in T_IDLE.
- cfg_busy_o  out  1  pending mode not yet applied.
- tx_evt_o  out  1  one-cycle TX completion event.
- rx_evt_o  out  1  one-cycle RX frame-available event.
- err_o  out  5  captured {tmo, crs_err, tx_err, rx_err, rx_crc_err}; valid with either event.

Behaviour:
- Reset (rst_i low, async): all outputs 0; both FSMs idle; no mode pending; timeout counter 0.
- sts_i is passed through a 2-flop synchronizer. All decisions below use the synchronized value s, so there are 2 cycles of input latency.
- Mode apply:
  - cfg_wr_i sets pending and sets cfg_busy_o on the next cycle.
  - The pending value is copied into ethmode bits {9,8,5,4,3,2,1} on the first cycle where the TX FSM is in T_IDLE and the RX FSM is in R_OFF or R_ARM. cfg_busy_o clears on that same edge.
  - A new cfg_wr_i while pending overwrites the pending value.
- TX FSM:
  - T_IDLE: on tx_req_i, latch tx_len_i into txcntb_o, go to T_SET. A tx_req_i outside T_IDLE is ignored. If a mode apply is due in the same cycle, the apply happens first and tx_req_i is honoured.
  - T_SET (1 cycle): set bit6, clear the counter, go to T_WAIT.
  - T_WAIT:
    - If s.txdone=1: capture the TX error bits, clear bit6, go to T_REL.
    - If the counter reaches TMO_MAX first: set tmo, clear bit6, go to T_REL.
  - T_REL: counter restarts. When s.txdone=0, or on a second timeout: pulse tx_evt_o with err_o, go to T_IDLE.
  - tx_len_i = 0 is legal and is passed through unchanged.
- RX FSM:
  - R_OFF: bit0=0. Go to R_ARM when rx_on_i=1.
  - R_ARM: bit0=1. If rx_on_i=0, go to R_OFF. If s.rxrdy=1, capture the RX error bits, pulse rx_evt_o, go to R_HOLD.
  - R_HOLD: wait for rx_ack_i. rx_on_i dropping here is deferred until ack. On ack, set bit7, clear the counter, go to R_DONE.
  - R_DONE:
    - When s.rxrdy=0: clear bit7, go to R_ARM (or R_OFF if rx_on_i=0).
    - On timeout: clear bit7, set tmo, pulse rx_evt_o again, go to R_OFF.
- Events:
  - TX and RX use separate counters.
  - err_o is registered with each event. If both events fire in the same cycle, err_o is the OR of both captures.
- Bits 6 and 7 are changed only by their own FSM, never by mode apply.

Test Plan:
- Reset check: hold rst_i=0 while toggling all inputs -> ethmode_o=10'h000, txcntb_o=0, all events 0. Release rst_i -> outputs stay 0 until the first command.
- TX handshake: tx_req_i with tx_len_i=11'd64; raise sts_i[5] 10 cycles later, drop it 5 cycles after that -> bit6 high from cycle+2 until 2 cycles after txdone rises; txcntb_o=64; exactly one tx_evt_o pulse with err_o=0.
- TX timeout (TMO_MAX=16 in the bench): tx_req_i with txdone never asserted -> bit6 falls after 16 cycles in T_WAIT; tx_evt_o pulses with err_o[4]=1; tx_busy_o=0 afterwards.
- RX frame: rx_on_i=1, then pulse sts_i[6] high with sts_i[0]=1 -> rx_evt_o pulses with err_o=5'b00001. rx_ack_i -> bit7 rises; drop rxrdy -> bit7 falls, bit0 stays 1.
- Deferred config: during T_WAIT, cfg_wr_i with cfg_i=7'b0000001 -> cfg_busy_o=1 and bit1=0 until T_REL exits; then bit1=1 and cfg_busy_o=0 in the same cycle.
- Reset mid-operation: assert rst_i in T_WAIT with bit6=1 -> ethmode_o=0 immediately (asynchronous); after release, a new tx_req_i completes normally.
